fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage: consumer of the next-PC produced by write-back. It holds the architectural PC, issues reads to a multi-cycle instruction memory, and buffers one fetched instruction for decode. It also handles hazard stalls, squashes in-flight reads on a redirect, and freezes on HALT. It sits between the write-back stage's PC output and the decode stage.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
- new_pc  in  16  redirect target from write-back (jump, branch, or pc+2)
- redirect  in  1  load new_pc into PC this cycle
- stall  in  1  decode hazard stall; the buffered instruction is not consumed
- halt  in  1  HALT decoded; stop fetching
- imem_addr  out  16  instruction memory address (= PC register)
- imem_rd  out  1  read request; held until accepted
- imem_stall  in  1  memory busy; the request is accepted on imem_rd && !imem_stall
- imem_done  in  1  read data valid this cycle
- imem_data  in  16  read data
- instr  out  16  buffered instruction
- pc_out  out  16  address of instr
- pc_plus2  out  16  pc_out + 2, modulo 2^16
- instr_valid  out  1  instr is valid for decode
- halted  out  1  fetch frozen
- err  out  1  misaligned redirect; sticky, only with FETCH_ERR_EN

## Operation
- Consume: instr_valid && !stall. The slot is free when !instr_valid or when it is consumed this cycle.
- States: FETCH, WAIT, SQUASH, HALTED.
- FETCH:
  - imem_rd=1 when the slot is free.
  - On accept with imem_done in the same cycle (hit): capture instr, set pc_out, assert instr_valid, PC <= PC+2, stay in FETCH.
  - On accept without imem_done: go to WAIT.
- WAIT:
  - imem_rd=0.
  - On imem_done: capture the instruction, PC <= PC+2, go to FETCH.
- SQUASH:
  - Entered when a redirect arrives while a read is in flight.
  - On imem_done: discard the data, go to FETCH.
- HALTED:
  - imem_rd=0, instr_valid=0, halted=1.
  - Exits only on reset.
- Redirect, in any state except HALTED:
  - PC <= new_pc; instr_valid <= 0 on the next edge.
  - From WAIT: go to SQUASH.
  - From SQUASH: stay in SQUASH.
  - From FETCH with a request accepted this cycle: data returned in the same cycle is discarded and the state stays FETCH; otherwise go to SQUASH.
  - From FETCH with no request accepted: stay in FETCH; imem_addr changes. An address change while imem_stall is high is legal.
- Halt:
  - Acts when halt && !stall && !redirect: go to HALTED and drop any in-flight data.
  - Redirect in the same cycle wins and halt is ignored, because the halting instruction is younger and is squashed.
- Stall with instr_valid: instr, pc_out and instr_valid hold; no new request is issued.
- Reset values: PC 0, imem_addr 0x0000, imem_rd 0, instr 0x0800 (NOP), pc_out 0x0000, pc_plus2 0x0002, instr_valid 0, halted 0, err 0, state FETCH.
- Reset mid-read: the read is abandoned. A late imem_done after reset is ignored unless the block is in WAIT.
- Arithmetic: 16-bit, wraps. PC 0xFFFE advances to 0x0000.

## Timing
- Hit latency: instr_valid 1 cycle after accept. Throughput 1 instruction per cycle with no stall.
- Miss: instr_valid asserts the cycle after imem_done.
- Redirect: the first request to new_pc is presented on the cycle after redirect when no read is in flight. Otherwise it is presented on the cycle after the squashed imem_done.
- All outputs are registered except imem_rd, which is decoded from state and slot-free.

## Configuration
- FETCH_ERR_EN defined:
  - A redirect with new_pc[0]==1 sets err=1 (sticky) and enters HALTED next cycle.
  - No request is issued to the odd address.
- FETCH_ERR_EN undefined:
  - new_pc[0] is forced to 0 and err is tied to 0.

## Test plan
- Hits: release rst, memory returns imem_done on accept with data 0x4001, 0x4002, 0x4003 → instr_valid on 3 consecutive cycles; pc_out 0x0000/0x0002/0x0004; pc_plus2 0x0002/0x0004/0x0006.
- Miss: imem_done 3 cycles after accept with data 0x1234 → instr=0x1234 and instr_valid the cycle after done; next imem_addr 0x0002.
- Squash: redirect to 0x0040 during WAIT; stale done with data 0xBEEF → 0xBEEF never appears on instr; next accepted imem_addr is 0x0040.
- Stall: instr_valid=1, stall held 3 cycles → instr/pc_out stable and imem_rd=0 throughout; fetch resumes the cycle stall drops.
- Halt, part 1: halt and redirect to 0x0100 in the same cycle → not halted; fetch at 0x0100.
- Halt, part 2: halt alone → halted=1 and imem_rd=0 for 20 cycles; rst=0 for one edge restores the reset values.
- Wrap and error: redirect to 0xFFFE with hits → next pc_out is 0x0000. Redirect to 0x0033 → with FETCH_ERR_EN, err=1 and halted=1; without it, fetch at 0x0032 and err=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory (slave).
interface fetch_unit_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;

  modport master (
    output imem_addr,
    output imem_rd,
    input  imem_stall,
    input  imem_done,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_rd,
    output imem_stall,
    output imem_done,
    output imem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, multi-cycle imem reads, one-entry decode buffer, redirect/halt.
// Optional macro FETCH_ERR_EN: misaligned redirects set a sticky err and halt fetch.
module fetch_unit (
  input  logic                clk_i,
  input  logic                rst_ni,
  fetch_unit_if.master        imem,
  input  logic [15:0]         new_pc_i,
  input  logic                redirect_i,
  input  logic                stall_i,
  input  logic                halt_i,
  output logic [15:0]         instr_o,
  output logic [15:0]         pc_out_o,
  output logic [15:0]         pc_plus2_o,
  output logic                instr_valid_o,
  output logic                halted_o,
  output logic                err_o
);

  typedef enum logic [1:0] {StFetch, StWait, StSquash, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic        accept;
  logic        capture;
  logic        in_flight;
  logic        redir_odd;
  logic [15:0] redir_pc;

`ifdef FETCH_ERR_EN
  assign redir_pc  = new_pc_i;
  assign redir_odd = new_pc_i[0];
`else
  assign redir_pc  = new_pc_i & 16'hFFFE;
  assign redir_odd = 1'b0;
`endif

  assign slot_free      = !valid_q || !stall_i;
  // Gated by reset so no request leaks out while rst_ni is held low.
  assign imem.imem_rd   = rst_ni && (state_q == StFetch) && slot_free;
  assign imem.imem_addr = pc_q;
  assign accept         = imem.imem_rd && !imem.imem_stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q && stall_i;
    capture    = 1'b0;
    in_flight  = 1'b0;

    // in_flight: a read is still outstanding after this edge.
    unique case (state_q)
      StFetch: begin
        if (accept) begin
          if (imem.imem_done) begin
            capture = 1'b1;
          end else begin
            state_d   = StWait;
            in_flight = 1'b1;
          end
        end
      end
      StWait: begin
        if (imem.imem_done) begin
          capture = 1'b1;
          state_d = StFetch;
        end else begin
          in_flight = 1'b1;
        end
      end
      StSquash: begin
        if (imem.imem_done) begin
          state_d = StFetch;
        end else begin
          in_flight = 1'b1;
        end
      end
      StHalted: valid_d = 1'b0;
      default:  state_d = StFetch;
    endcase

    // Redirect outranks halt: the halting instruction is younger and gets squashed.
    if (redirect_i && state_q != StHalted) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      if (redir_odd) begin
        state_d = StHalted;
      end else if (in_flight) begin
        state_d = StSquash;
      end else begin
        state_d = StFetch;
      end
    end else if (halt_i && !stall_i && state_q != StHalted) begin
      state_d = StHalted;
      valid_d = 1'b0;
    end else if (capture) begin
      instr_d    = imem.imem_data;
      pc_out_d   = pc_q;
      pc_plus2_d = pc_q + 16'd2;
      pc_d       = pc_q + 16'd2;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StFetch;
      pc_q       <= 16'h0000;
      instr_q    <= 16'h0800;
      pc_out_q   <= 16'h0000;
      pc_plus2_q <= 16'h0002;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (redirect_i && redir_odd && state_q != StHalted) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign instr_o       = instr_q;
  assign pc_out_o      = pc_out_q;
  assign pc_plus2_o    = pc_plus2_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table with scoreboard plus corner-case sequences.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] new_pc;
  logic        redirect, stall, halt;
  logic [15:0] instr, pc_out, pc_plus2;
  logic        instr_valid, halted, err;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem          (bus),
    .new_pc_i      (new_pc),
    .redirect_i    (redirect),
    .stall_i       (stall),
    .halt_i        (halt),
    .instr_o       (instr),
    .pc_out_o      (pc_out),
    .pc_plus2_o    (pc_plus2),
    .instr_valid_o (instr_valid),
    .halted_o      (halted),
    .err_o         (err)
  );

  // Memory model: lat==0 answers in the accept cycle, otherwise lat cycles later.
  int unsigned lat = 0;
  logic [15:0] rdata = 16'h0000;
  logic        mem_stall = 1'b0;
  logic        busy = 1'b0;
  int unsigned cnt = 0;
  logic [15:0] pend_data = 16'h0000;
  logic        accept, hit_now;

  assign accept         = bus.imem_rd && !bus.imem_stall;
  assign hit_now        = accept && (lat == 0);
  assign bus.imem_stall = mem_stall;
  assign bus.imem_done  = hit_now || (busy && cnt == 1);
  assign bus.imem_data  = hit_now ? rdata : pend_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else if (accept && lat != 0) begin
      busy      <= 1'b1;
      cnt       <= lat;
      pend_data <= rdata;
    end else if (busy) begin
      if (cnt == 1) busy <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t e_pop, e_push;
  logic sb_en = 1'b0;

  // Each consumed instruction is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (sb_en && instr_valid && !stall) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_valid", {15'd0, instr_valid}, 16'd0);
      end else begin
        e_pop = sbq.pop_front();
        check("sb_instr", instr, e_pop.data);
        check("sb_pc_out", pc_out, e_pop.pc);
        check("sb_pc_plus2", pc_plus2, e_pop.pc + 16'd2);
      end
    end
  end

  typedef struct {
    int unsigned lat;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[8];

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name, output logic [15:0] addr);
    bit got = 1'b0;
    addr = 16'h0000;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (accept) begin
        got  = 1'b1;
        addr = bus.imem_addr;
      end else begin
        drive_pt();
      end
    end
    check({name, "_seen"}, {15'd0, got}, 16'd1);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_addr"}, bus.imem_addr, 16'h0000);
    check({p, "_rd"}, {15'd0, bus.imem_rd}, 16'd0);
    check({p, "_instr"}, instr, 16'h0800);
    check({p, "_pc_out"}, pc_out, 16'h0000);
    check({p, "_pc_plus2"}, pc_plus2, 16'h0002);
    check({p, "_valid"}, {15'd0, instr_valid}, 16'd0);
    check({p, "_halted"}, {15'd0, halted}, 16'd0);
    check({p, "_err"}, {15'd0, err}, 16'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    redirect  = 1'b0;
    halt      = 1'b0;
    stall     = 1'b0;
    mem_stall = 1'b0;
    lat       = 0;
    drive_pt();
    rst_n = 1'b1;
  endtask

  logic [15:0] a;
  int unsigned acc_cyc[8];
  int          bad;
  bit          seen, stale, got;

  initial begin
    rst_n    = 1'b0;
    new_pc   = 16'h0000;
    redirect = 1'b0;
    stall    = 1'b0;
    halt     = 1'b0;

    vecs[0] = '{lat: 0, addr: 16'h0000, data: 16'h4001};
    vecs[1] = '{lat: 0, addr: 16'h0002, data: 16'h4002};
    vecs[2] = '{lat: 0, addr: 16'h0004, data: 16'h4003};
    vecs[3] = '{lat: 3, addr: 16'h0006, data: 16'h1234};
    vecs[4] = '{lat: 0, addr: 16'h0008, data: 16'h5555};
    vecs[5] = '{lat: 1, addr: 16'h000A, data: 16'h0A0A};
    vecs[6] = '{lat: 2, addr: 16'h000C, data: 16'h0C0C};
    vecs[7] = '{lat: 0, addr: 16'h000E, data: 16'h0E0E};

    drive_pt();
    @(negedge clk);
    check_reset_vals("rst");
    drive_pt();
    rst_n = 1'b1;

    // Vector table: hits and misses streamed through the scoreboard.
    sb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lat   = vecs[i].lat;
      rdata = vecs[i].data;
      wait_accept("tbl_acc", a);
      check("tbl_addr", a, vecs[i].addr);
      acc_cyc[i] = cyc;
      e_push.pc   = vecs[i].addr;
      e_push.data = vecs[i].data;
      sbq.push_back(e_push);
      drive_pt();
      if (i == 7) mem_stall = 1'b1;
    end
    check("hit_throughput", 16'(acc_cyc[2] - acc_cyc[0]), 16'd2);
    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
    check("sb_drain", 16'(sbq.size()), 16'd0);
    sb_en = 1'b0;
    drive_pt();

    // Miss: done three cycles after accept, instr_valid the cycle after done.
    do_reset();
    lat   = 3;
    rdata = 16'h1234;
    mem_stall = 1'b0;
    wait_accept("miss_acc", a);
    check("miss_addr", a, 16'h0000);
    drive_pt();
    mem_stall = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.imem_done) seen = 1'b1;
      else drive_pt();
    end
    check("miss_done_seen", {15'd0, seen}, 16'd1);
    check("miss_valid_early", {15'd0, instr_valid}, 16'd0);
    drive_pt();
    @(negedge clk);
    check("miss_valid", {15'd0, instr_valid}, 16'd1);
    check("miss_instr", instr, 16'h1234);
    check("miss_next_addr", bus.imem_addr, 16'h0002);
    drive_pt();

    // Squash: redirect during WAIT; stale data must never reach instr.
    do_reset();
    lat   = 3;
    rdata = 16'hBEEF;
    wait_accept("sq_acc", a);
    drive_pt();
    redirect = 1'b1;
    new_pc   = 16'h0040;
    drive_pt();
    redirect = 1'b0;
    lat      = 0;
    rdata    = 16'h7777;
    stale    = 1'b0;
    got      = 1'b0;
    a        = 16'h0000;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (instr_valid && instr == 16'hBEEF) stale = 1'b1;
      if (accept) begin
        got = 1'b1;
        a   = bus.imem_addr;
      end else begin
        drive_pt();
      end
    end
    check("sq_stale", {15'd0, stale}, 16'd0);
    check("sq_got", {15'd0, got}, 16'd1);
    check("sq_addr", a, 16'h0040);
    drive_pt();
    @(negedge clk);
    check("sq_instr", instr, 16'h7777);
    check("sq_pc_out", pc_out, 16'h0040);
    drive_pt();

    // Stall: buffered instruction holds, no requests while stalled.
    do_reset();
    lat   = 0;
    rdata = 16'h2222;
    wait_accept("st_acc", a);
    drive_pt();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("st_instr", instr, 16'h2222);
      check("st_pc_out", pc_out, 16'h0000);
      check("st_valid", {15'd0, instr_valid}, 16'd1);
      check("st_rd", {15'd0, bus.imem_rd}, 16'd0);
      drive_pt();
    end
    stall = 1'b0;
    @(negedge clk);
    check("st_resume_rd", {15'd0, bus.imem_rd}, 16'd1);
    check("st_resume_addr", bus.imem_addr, 16'h0002);
    drive_pt();

    // Halt with redirect in the same cycle: redirect wins.
    do_reset();
    mem_stall = 1'b1;
    halt      = 1'b1;
    redirect  = 1'b1;
    new_pc    = 16'h0100;
    drive_pt();
    halt     = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    check("hr_halted", {15'd0, halted}, 16'd0);
    check("hr_addr", bus.imem_addr, 16'h0100);
    check("hr_rd", {15'd0, bus.imem_rd}, 16'd1);
    drive_pt();
    mem_stall = 1'b0;
    rdata     = 16'h1111;
    wait_accept("hr_acc", a);
    check("hr_acc_addr", a, 16'h0100);
    drive_pt();

    // Halt alone: frozen until reset.
    halt = 1'b1;
    drive_pt();
    halt = 1'b0;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!halted || bus.imem_rd || instr_valid) bad++;
      drive_pt();
    end
    check("halt_hold", 16'(bad), 16'd0);
    @(negedge clk);
    check("halt_flag", {15'd0, halted}, 16'd1);
    drive_pt();
    rst_n = 1'b0;
    drive_pt();
    @(negedge clk);
    check_reset_vals("halt_rst");
    drive_pt();
    rst_n = 1'b1;

    // Wrap: 0xFFFE advances to 0x0000.
    do_reset();
    mem_stall = 1'b1;
    redirect  = 1'b1;
    new_pc    = 16'hFFFE;
    drive_pt();
    redirect  = 1'b0;
    mem_stall = 1'b0;
    rdata     = 16'h3333;
    wait_accept("wr_acc", a);
    check("wr_acc_addr", a, 16'hFFFE);
    drive_pt();
    @(negedge clk);
    check("wr_pc_out", pc_out, 16'hFFFE);
    check("wr_pc_plus2", pc_plus2, 16'h0000);
    check("wr_next_addr", bus.imem_addr, 16'h0000);
    drive_pt();
    @(negedge clk);
    check("wr_pc_out_wrapped", pc_out, 16'h0000);
    drive_pt();

    // Misaligned redirect.
    do_reset();
    mem_stall = 1'b1;
    redirect  = 1'b1;
    new_pc    = 16'h0033;
    drive_pt();
    redirect  = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
`ifdef FETCH_ERR_EN
    check("odd_err", {15'd0, err}, 16'd1);
    check("odd_halted", {15'd0, halted}, 16'd1);
    check("odd_rd", {15'd0, bus.imem_rd}, 16'd0);
`else
    check("odd_addr", bus.imem_addr, 16'h0032);
    check("odd_err", {15'd0, err}, 16'd0);
    check("odd_halted", {15'd0, halted}, 16'd0);
`endif
    drive_pt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
